// File: rtl/ido_pipe_buffer_if.sv
// Handshake bundle for ido_pipe_buffer: upstream push side, downstream pop side and occupancy.
interface ido_pipe_buffer_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/ido_pipe_buffer.sv
// FIFO elastic buffer with registered occupancy and synchronous flush.
// Define IDO_BUF_BYPASS_EN to pass a word straight through when empty and downstream is ready.
module ido_pipe_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    ido_pipe_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;

    always_comb begin
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
`ifdef IDO_BUF_BYPASS_EN
        bypass = empty && !flush && bus.in_valid && bus.out_ready;
`else
        bypass = 1'b0;
`endif
        // a bypassed word is consumed downstream and never occupies storage
        push = bus.in_valid && !full && !flush && !bypass;
        pop  = !empty && bus.out_ready && !flush;
    end

    always_comb begin
        bus.in_ready  = !full;
        bus.count     = count;
        bus.out_valid = !empty || bypass;
        bus.out_data  = '0;
        if (bypass) begin
            bus.out_data = bus.in_data;
        end else if (!empty) begin
            bus.out_data = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_ido_pipe_buffer.sv
// Directed bench for ido_pipe_buffer: reset, fill, drain, wrap, flush, mid-stream reset, bypass/latency.
module tb_ido_pipe_buffer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_chk;
    int   n_pass;

    ido_pipe_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    ido_pipe_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid  = 1'b0;
    endtask

    logic [15:0] wexp [12];

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_count", 32'(bus.count), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_data", 32'(bus.out_data), 0);
        rst_n = 1'b1;
        step();
        check("rel_count", 32'(bus.count), 0);

        // fill with downstream stalled
        for (int k = 1; k <= 4; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 16'(k);
            bus.out_ready = 1'b0;
            step();
            if (k == 1) begin
                check("lat_valid", 32'(bus.out_valid), 1);
                check("lat_data", 32'(bus.out_data), 1);
            end
            check("fill_count", 32'(bus.count), 32'(k));
        end
        check("full_in_ready", 32'(bus.in_ready), 0);
        bus.in_data = 16'h0005;
        #1;
        check("stall_data", 32'(bus.out_data), 1);

        // drain; 0x0005 offered while full must be ignored
        bus.out_ready = 1'b1;
        #1;
        check("drain_data_1", 32'(bus.out_data), 1);
        step();
        bus.in_valid = 1'b0;
        check("full_pop_count", 32'(bus.count), 3);
        for (int k = 2; k <= 4; k++) begin
            #1;
            check("drain_data", 32'(bus.out_data), 32'(k));
            step();
        end
        check("drained_valid", 32'(bus.out_valid), 0);
        check("drained_count", 32'(bus.count), 0);

        // wrap: steady push+pop at occupancy 2
        wexp[0] = 16'h00F0;
        wexp[1] = 16'h00F1;
        for (int i = 0; i < 10; i++) wexp[i+2] = 16'h0100 + 16'(i);
        push_word(16'h00F0);
        push_word(16'h00F1);
        check("wrap_pre_count", 32'(bus.count), 2);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 16'h0100 + 16'(i);
            bus.out_ready = 1'b1;
            #1;
            check("wrap_data", 32'(bus.out_data), 32'(wexp[i]));
            step();
            check("wrap_count", 32'(bus.count), 2);
        end
        bus.in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            #1;
            check("wrap_tail", 32'(bus.out_data), 32'(wexp[i]));
            step();
        end
        check("wrap_empty", 32'(bus.out_valid), 0);

        // flush with a push attempt in the same cycle
        push_word(16'h0011);
        push_word(16'h0022);
        push_word(16'h0033);
        check("pre_flush_count", 32'(bus.count), 3);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hBEEF;
        bus.out_ready = 1'b1;
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_count", 32'(bus.count), 0);
        check("flush_valid", 32'(bus.out_valid), 0);
        step();
        check("flush_no_beef", 32'(bus.count), 0);
        push_word(16'h0042);
        check("post_flush_data", 32'(bus.out_data), 16'h0042);
        check("post_flush_count", 32'(bus.count), 1);

        // asynchronous reset mid-stream at occupancy 3
        push_word(16'h0043);
        push_word(16'h0044);
        check("pre_rst_count", 32'(bus.count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.count), 0);
        check("async_rst_valid", 32'(bus.out_valid), 0);
        check("async_rst_ready", 32'(bus.in_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_count", 32'(bus.count), 0);
        push_word(16'h0077);
        check("rst_push_data", 32'(bus.out_data), 16'h0077);
        check("rst_push_count", 32'(bus.count), 1);
        bus.out_ready = 1'b1;
        step();
        check("rst_pop_empty", 32'(bus.count), 0);

        // empty buffer, word offered with downstream ready
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h00AA;
        bus.out_ready = 1'b1;
        #1;
`ifdef IDO_BUF_BYPASS_EN
        check("byp_valid", 32'(bus.out_valid), 1);
        check("byp_data", 32'(bus.out_data), 16'h00AA);
        step();
        bus.in_valid = 1'b0;
        #1;
        check("byp_count", 32'(bus.count), 0);
        check("byp_after_valid", 32'(bus.out_valid), 0);
`else
        check("nobyp_valid", 32'(bus.out_valid), 0);
        step();
        bus.in_valid = 1'b0;
        #1;
        check("nobyp_lat_valid", 32'(bus.out_valid), 1);
        check("nobyp_lat_data", 32'(bus.out_data), 16'h00AA);
        check("nobyp_count", 32'(bus.count), 1);
        step();
        check("nobyp_drained", 32'(bus.count), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
